// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped machine timer.
// Holds the register word indices, CTRL bit positions and the bus handshake states.
package bus_timer_pkg;

  // Word index taken from address bits [4:2].
  localparam logic [2:0] REG_MTIME_LO = 3'd0;
  localparam logic [2:0] REG_MTIME_HI = 3'd1;
  localparam logic [2:0] REG_CMP_LO   = 3'd2;
  localparam logic [2:0] REG_CMP_HI   = 3'd3;
  localparam logic [2:0] REG_CTRL     = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;

  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IE = 1;

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

endpackage

// File: rtl/bus_timer_if.sv
// Single-initiator SoC bus as seen by one target.
//   request : held high by the master until ready is seen
//   rw      : 1 = write, 0 = read
//   address : byte address
//   wdata   : write data
//   rdata   : read data, valid while ready = 1
//   ready   : transaction acknowledge
interface bus_timer_if;
  logic        request;
  logic        rw;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output request,
    output rw,
    output address,
    output wdata,
    input  rdata,
    input  ready
  );

  modport slave (
    input  request,
    input  rw,
    input  address,
    input  wdata,
    output rdata,
    output ready
  );
endinterface

// File: rtl/bus_timer_prescaler.sv
// Divides the system clock down to the mtime tick rate.
//   i_clock  : system clock
//   i_reset  : synchronous, active-high reset
//   i_enable : count enable; while low the count is held at 0
//   o_tick   : one-cycle pulse on the cycle the count wraps from PRESCALE-1 to 0
module bus_timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_tick
);
  localparam int unsigned CountWidth = $clog2(PRESCALE + 1);
  localparam logic [CountWidth-1:0] CountMax = CountWidth'(PRESCALE - 1);

  logic [CountWidth-1:0] count_q, count_d;

  always_comb begin
    o_tick  = i_enable && (count_q == CountMax);
    count_d = count_q + CountWidth'(1);
    if (!i_enable || o_tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/bus_timer.sv
// Memory-mapped machine timer: 64-bit mtime advanced by a prescaled tick, a 64-bit
// mtimecmp, and a registered level interrupt for the CPU.
//   i_clock     : system clock
//   i_reset     : synchronous, active-high reset
//   bus         : bus target port (request/rw/address/wdata in, rdata/ready out)
//   o_interrupt : registered IE && (mtime >= mtimecmp)
// Register words (address[4:2]): 0 MTIME_LO, 1 MTIME_HI (reads the shadow captured by the
// last MTIME_LO read), 2 CMP_LO, 3 CMP_HI, 4 CTRL {IE, EN}, 5 STATUS {mtime >= mtimecmp},
// 6-7 read 0 / writes ignored.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int unsigned FREQUENCY      = 25000000,
  parameter int unsigned TICK_FREQUENCY = 1000000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  bus_timer_if.slave bus,
  output logic       o_interrupt
);
  localparam int unsigned PRESCALE = FREQUENCY / TICK_FREQUENCY;

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("bus_timer: FREQUENCY / TICK_FREQUENCY must be >= 1");
  end

  state_t      state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        irq_q, irq_d;
  logic        tick;
  logic        access;
  logic        cmp_hit;
  logic [2:0]  reg_idx;
  logic        unused_addr;

  assign reg_idx     = bus.address[4:2];
  assign unused_addr = ^{bus.address[31:5], bus.address[1:0]};
  assign cmp_hit     = mtime_q >= mtimecmp_q;

  bus_timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_enable(ctrl_q[CTRL_EN]),
    .o_tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    rdata_d    = rdata_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;
    shadow_d   = shadow_q;
    access     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.request) begin
          access  = 1'b1;
          ready_d = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!bus.request) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
    endcase

    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    // A write to either mtime half overrides the whole increment, so no carry leaks.
    if (access && bus.rw) begin
      case (reg_idx)
        REG_MTIME_LO: mtime_d = {mtime_q[63:32], bus.wdata};
        REG_MTIME_HI: mtime_d = {bus.wdata, mtime_q[31:0]};
        REG_CMP_LO:   mtimecmp_d[31:0]  = bus.wdata;
        REG_CMP_HI:   mtimecmp_d[63:32] = bus.wdata;
        REG_CTRL:     ctrl_d = bus.wdata[1:0];
        default: ;
      endcase
    end

    if (access && !bus.rw) begin
      case (reg_idx)
        REG_MTIME_LO: begin
          rdata_d  = mtime_q[31:0];
          shadow_d = mtime_q[63:32];
        end
        REG_MTIME_HI: rdata_d = shadow_q;
        REG_CMP_LO:   rdata_d = mtimecmp_q[31:0];
        REG_CMP_HI:   rdata_d = mtimecmp_q[63:32];
        REG_CTRL:     rdata_d = {30'd0, ctrl_q};
        REG_STATUS:   rdata_d = {31'd0, cmp_hit};
        default:      rdata_d = 32'd0;
      endcase
    end

    irq_d = ctrl_q[CTRL_IE] && cmp_hit;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= '1;
      ctrl_q     <= 2'b01;
      shadow_q   <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      shadow_q   <= shadow_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.rdata   = rdata_q;
  assign o_interrupt = irq_q;
endmodule

// File: tb/tb_bus_timer.sv
module tb_bus_timer;
  import bus_timer_pkg::*;

  localparam int unsigned P0 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_timer_if bus0();
  bus_timer_if bus1();
  logic irq0, irq1;

  bus_timer #(.FREQUENCY(4), .TICK_FREQUENCY(1)) u_dut0 (
    .i_clock(clk), .i_reset(rst), .bus(bus0), .o_interrupt(irq0)
  );
  bus_timer #(.FREQUENCY(1), .TICK_FREQUENCY(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .bus(bus1), .o_interrupt(irq1)
  );

  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Behavioural model of DUT0 (PRESCALE = 4), advanced once per clock edge.
  logic [63:0] m_mtime, m_cmp;
  logic [1:0]  m_ctrl;
  int unsigned m_phase;
  logic [31:0] m_shadow, m_rdata;
  logic        m_ready, m_irq, m_rd;

  function automatic logic [31:0] model_read(input logic [2:0] idx);
    case (idx)
      3'd0:    return m_mtime[31:0];
      3'd1:    return m_shadow;
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {30'd0, m_ctrl};
      3'd5:    return {31'd0, m_mtime >= m_cmp};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic        tick;
    logic [63:0] nt, nc;
    logic [1:0]  nctl;
    int unsigned nph;
    logic [31:0] nsh, nrd;
    logic        nirq;
    logic [2:0]  widx;
    cyc++;
    if (rst) begin
      m_mtime = 64'd0; m_cmp = '1; m_ctrl = 2'b01; m_phase = 0;
      m_shadow = 32'd0; m_rdata = 32'd0; m_ready = 1'b0; m_irq = 1'b0; m_rd = 1'b0;
    end else begin
      tick = m_ctrl[0] && (m_phase == P0 - 1);
      nph  = (!m_ctrl[0] || tick) ? 0 : m_phase + 1;
      nt   = tick ? m_mtime + 64'd1 : m_mtime;
      nc   = m_cmp; nctl = m_ctrl; nsh = m_shadow; nrd = m_rdata;
      nirq = m_ctrl[1] && (m_mtime >= m_cmp);
      if (bus0.request && !m_ready) begin
        widx = bus0.address[4:2];
        m_rd = !bus0.rw;
        if (bus0.rw) begin
          case (widx)
            3'd0: nt = {m_mtime[63:32], bus0.wdata};
            3'd1: nt = {bus0.wdata, m_mtime[31:0]};
            3'd2: nc[31:0] = bus0.wdata;
            3'd3: nc[63:32] = bus0.wdata;
            3'd4: nctl = bus0.wdata[1:0];
            default: ;
          endcase
        end else begin
          nrd = model_read(widx);
          if (widx == 3'd0) nsh = m_mtime[63:32];
        end
      end
      m_mtime = nt; m_cmp = nc; m_ctrl = nctl; m_phase = nph;
      m_shadow = nsh; m_rdata = nrd; m_irq = nirq;
      m_ready = bus0.request;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", bus0.ready, m_ready);
      check("irq", irq0, m_irq);
      if (m_ready && m_rd) check("rdata", bus0.rdata, m_rdata);
    end
  end

  int unsigned commit_cyc;
  int          ready_cnt;
  logic        irq_ack, irq_after;

  task automatic drive(input bit sel, input logic req, input logic rw, input logic [31:0] a,
                       input logic [31:0] wd);
    if (sel) begin
      bus1.request = req; bus1.rw = rw; bus1.address = a; bus1.wdata = wd;
    end else begin
      bus0.request = req; bus0.rw = rw; bus0.address = a; bus0.wdata = wd;
    end
  endtask

  // One transaction: raise request on a falling edge, hold for `hold` acked cycles, drop.
  task automatic bus_op(input bit sel, input bit rw, input logic [2:0] idx, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd);
    logic [31:0] a;
    a = $urandom();
    a[4:2] = idx;
    drive(sel, 1'b1, rw, a, wd);
    @(negedge clk);
    commit_cyc = cyc;
    check("ack_latency", sel ? bus1.ready : bus0.ready, 1);
    rd = sel ? bus1.rdata : bus0.rdata;
    irq_ack = sel ? irq1 : irq0;
    ready_cnt = 1;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      if (sel ? bus1.ready : bus0.ready) ready_cnt++;
    end
    drive(sel, 1'b0, rw, a, wd);
    @(negedge clk);
    irq_after = sel ? irq1 : irq0;
    check("ready_drop", sel ? bus1.ready : bus0.ready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a1, b1, lo1, hi1;
    int unsigned e, r1, r2;
    logic [2:0]  idx;
    logic        rw;
    logic [31:0] wd;

    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready0", bus0.ready, 0);
    check("rst_rdata0", bus0.rdata, 0);
    check("rst_irq0", irq0, 0);
    check("rst_ready1", bus1.ready, 0);
    rst = 1'b0;

    // Tick every 4 cycles: 40 cycles after reset mtime is about 10.
    repeat (40) @(negedge clk);
    bus_op(0, 0, REG_MTIME_LO, 0, 1, rd);
    total++;
    if (rd < 32'd9 || rd > 32'd11) begin
      bad++;
      $display("FAIL mtime_after_40: got %0d want 10+-1", rd);
    end
    bus_op(0, 0, REG_MTIME_HI, 0, 1, rd);
    check("mtime_hi_0", rd, 0);
    bus_op(0, 0, REG_STATUS, 0, 1, rd);
    check("status_0", rd, 0);
    check("irq_idle", irq0, 0);

    // Interrupt rises one cycle after the tick that makes mtime = 20.
    bus_op(0, 1, REG_CMP_HI, 0, 1, rd);
    bus_op(0, 1, REG_CMP_LO, 20, 1, rd);
    bus_op(0, 1, REG_CTRL, 3, 1, rd);
    for (int i = 0; i < 200 && m_mtime != 64'd20; i++) @(negedge clk);
    check("reach_mtime20", m_mtime, 20);
    check("irq_before_rise", irq0, 0);
    @(negedge clk);
    check("irq_rise", irq0, 1);
    bus_op(0, 1, REG_CMP_LO, 100, 1, rd);
    check("irq_at_cmp_ack", irq_ack, 1);
    check("irq_cleared", irq_after, 0);

    // Long request: one commit, ready for 5 cycles, counter frozen.
    bus_op(0, 1, REG_CTRL, 0, 5, rd);
    check("hold_ready_cycles", ready_cnt, 5);
    bus_op(0, 0, REG_MTIME_LO, 0, 1, a1);
    repeat (12) @(negedge clk);
    bus_op(0, 0, REG_MTIME_LO, 0, 2, b1);
    check("mtime_frozen", b1, a1);
    bus_op(0, 0, REG_CTRL, 0, 1, rd);
    check("ctrl_0", rd, 0);

    // Write MTIME_LO on a tick edge: the tick is dropped.
    bus_op(0, 1, REG_CTRL, 1, 1, rd);
    for (int i = 0; i < 10 && m_phase != P0 - 1; i++) @(negedge clk);
    bus_op(0, 1, REG_MTIME_LO, 5, 1, rd);
    bus_op(0, 0, REG_MTIME_LO, 0, 1, rd);
    check("tick_dropped", rd, 5);
    bus_op(0, 0, 3'd6, 0, 1, rd);
    check("idx6_zero", rd, 0);
    bus_op(0, 1, 3'd7, 32'hFFFF_FFFF, 1, rd);
    bus_op(0, 0, 3'd7, 0, 1, rd);
    check("idx7_zero", rd, 0);

    // Reset while in ACK.
    drive(0, 1'b1, 1'b1, {27'd0, REG_CMP_LO, 2'b00}, 32'd7);
    @(negedge clk);
    check("ack_before_reset", bus0.ready, 1);
    rst = 1'b1;
    drive(0, 1'b0, 1'b1, {27'd0, REG_CMP_LO, 2'b00}, 32'd7);
    @(negedge clk);
    check("reset_in_ack_ready", bus0.ready, 0);
    rst = 1'b0;
    @(negedge clk);
    bus_op(0, 0, REG_CMP_LO, 0, 1, rd);
    check("cmp_lo_after_reset", rd, 32'hFFFF_FFFF);
    bus_op(0, 0, REG_CMP_HI, 0, 1, rd);
    check("cmp_hi_after_reset", rd, 32'hFFFF_FFFF);
    bus_op(0, 0, REG_CTRL, 0, 1, rd);
    check("ctrl_after_reset", rd, 1);

    // PRESCALE = 1 instance: 32-bit carry and tear-free LO/HI reads.
    bus_op(1, 1, REG_MTIME_HI, 0, 1, rd);
    bus_op(1, 1, REG_MTIME_LO, 32'hFFFF_FFFE, 1, rd);
    e = commit_cyc;
    bus_op(1, 0, REG_MTIME_LO, 0, 1, lo1);
    r1 = commit_cyc;
    bus_op(1, 0, REG_MTIME_HI, 0, 1, hi1);
    check("p1_pair1", {hi1, lo1}, 64'hFFFF_FFFE + 64'(r1 - e - 1));
    bus_op(1, 0, REG_MTIME_LO, 0, 1, lo1);
    r2 = commit_cyc;
    bus_op(1, 0, REG_MTIME_HI, 0, 1, hi1);
    check("p1_pair2", {hi1, lo1}, 64'hFFFF_FFFE + 64'(r2 - e - 1));
    check("p1_hi_crossed", hi1, 1);
    check("p1_irq", irq1, 0);

    // Randomized traffic on the PRESCALE = 4 instance.
    for (int t = 0; t < 300; t++) begin
      idx = 3'($urandom_range(7, 0));
      rw  = 1'($urandom_range(1, 0));
      case (idx)
        3'd0: wd = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15, 0)
                                                : $urandom_range(200, 0);
        3'd1: wd = ($urandom_range(3, 0) == 0) ? $urandom() : 32'd0;
        3'd2: wd = m_mtime[31:0] + $urandom_range(40, 0) - 32'd20;
        3'd3: wd = ($urandom_range(7, 0) == 0) ? $urandom() : m_mtime[63:32];
        default: wd = $urandom();
      endcase
      bus_op(0, rw, idx, wd, $urandom_range(3, 1), rd);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
